nonce_result_collector: RTL
===========================

# nonce_result_collector

Downstream companion of the hash validator. It pairs each nonce issued into the hashing path with the validator's delayed `success` bit and captures winning nonces into a small show-ahead FIFO. The host/UART side drains that FIFO over a valid/ready handshake. The block also keeps a sticky overflow flag and, optionally, a saturating count of hits.

## Interface
Parameters:
- `LATENCY`, default 1: cycles from `nonce_valid_i` to the matching `success_i`. Range 1..64.
- `DEPTH`, default 4: FIFO entries. Power of two, 2..16.

Ports:
- `clk`, input, 1: sole clock. All logic is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `nonce_valid_i`, input, 1: a hash for `nonce_i` enters the validator this cycle.
- `nonce_i`, input, 32: nonce of that hash.
- `success_i`, input, 1: validator result, arriving exactly `LATENCY` cycles after its `nonce_valid_i`.
- `clear_i`, input, 1: synchronous flush, used on a new job.
- `result_valid_o`, output, 1: FIFO non-empty.
- `result_nonce_o`, output, 32: head-of-FIFO nonce.
- `result_ready_i`, input, 1: consumer accepts the head.
- `overflow_o`, output, 1: sticky; a hit was dropped.
- `found_count_o`, output, 16: saturating hit count. See Configuration.

## Operation
- Delay line: `LATENCY` stages of {valid, nonce[31:0]}, shifted every cycle with no stall. Stage `LATENCY-1` is aligned with `success_i`.
- Hit: aligned valid = 1 and `success_i` = 1. `success_i` is ignored when the aligned valid = 0.
- Push: a hit writes the aligned nonce at the write pointer.
- Pop: `result_valid_o && result_ready_i` advances the read pointer.
- Pointers: log2(DEPTH)+1 bits with a wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ.
- Full FIFO with a hit and no pop in the same cycle: the new nonce is dropped, `overflow_o` sets, and FIFO contents are unchanged.
- Full FIFO with a hit and a pop in the same cycle: both happen, there is no overflow, and occupancy stays at DEPTH.
- Empty FIFO with a hit: the entry is written. `result_valid_o` rises the next cycle. Data does not bypass the FIFO.
- `overflow_o` clears only on reset or `clear_i`.
- `clear_i` = 1 at a clock edge:
  - Zeroes the delay-line valids, both pointers, `overflow_o` and `found_count_o`.
  - Any push or pop in that cycle is discarded.
  - Delay-line nonce data may keep stale values.
- Reset value of every output: `result_valid_o` = 0, `result_nonce_o` = 0, `overflow_o` = 0, `found_count_o` = 0. Delay-line valids = 0.
- Reset asserted mid-operation: the same state, immediately and asynchronously. In-flight and buffered nonces are lost.

## Timing
- Latency from `nonce_valid_i` at edge t to `result_valid_o` high is `LATENCY`+1 edges, when the FIFO is empty and not full.
- `result_nonce_o` is stable while `result_valid_o` = 1 and `result_ready_i` = 0.
- After a pop, the next entry appears on the following cycle. Back-to-back pops drain one entry per cycle.
- `result_valid_o` may not depend combinationally on `result_ready_i`.
- `overflow_o` rises one edge after the dropping hit.
- `found_count_o` updates one edge after the hit.
- Throughput: one nonce per cycle accepted indefinitely, because the delay line never stalls.

## Configuration
- Macro: `RESULT_COUNT_EN`.
- Defined: `found_count_o` increments on every hit, including dropped ones. It saturates at 16'hFFFF and clears on reset or `clear_i`.
- Undefined: the counter is not built and `found_count_o` is tied to 0. All other behaviour is identical.

## Test plan
- Single hit, LATENCY=1, DEPTH=4:
  - Stimulus: `nonce_i`=32'h0000_1234 valid at edge 0; `success_i`=1 at edge 1; `result_ready_i`=0.
  - Required: `result_valid_o`=1 and `result_nonce_o`=32'h0000_1234 from edge 2; it holds until ready; one pop empties the FIFO.
- Misses and an orphan success:
  - Stimulus: 8 consecutive nonces with `success_i`=0; then `success_i`=1 while the aligned valid=0.
  - Required: `result_valid_o` stays 0 and `found_count_o`=0.
- Overflow, DEPTH=4:
  - Stimulus: 5 consecutive hits with nonces 1..5 and `result_ready_i`=0.
  - Required: the FIFO holds 1,2,3,4; `overflow_o`=1 after the 5th hit; with `RESULT_COUNT_EN` defined, `found_count_o`=5.
- Full FIFO with simultaneous push and pop:
  - Stimulus: FIFO full with 1..4; hit with nonce 6 while `result_ready_i`=1.
  - Required: `overflow_o` stays 0; the pop order that follows is 2,3,4,6.
- Clear and reset:
  - Stimulus: with 2 entries buffered and a hit in flight at LATENCY=3, pulse `clear_i`; later drop `rst` mid-stream.
  - Required: after each, `result_valid_o`=0, `overflow_o`=0 and `found_count_o`=0, and the in-flight hit never appears.
- Macro off, with `RESULT_COUNT_EN` undefined:
  - Stimulus: the overflow scenario.
  - Required: the same FIFO behaviour, and `found_count_o`=0 throughout.

Source files
------------

// File: rtl/nonce_result_collector.sv
// Pairs issued nonces with delayed validator success; winners go to a show-ahead FIFO. Optional hit counter: RESULT_COUNT_EN.
// Latency: nonce_valid_i to result_valid_o is LATENCY+1 edges (no bypass); delay line never stalls.
// Backpressure: result_valid_o/result_ready_i drain; hits arriving on a full FIFO without a pop are dropped and flag overflow_o.
module nonce_result_collector #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nonce_valid_i,
  input  logic [31:0] nonce_i,
  input  logic        success_i,
  input  logic        clear_i,
  output logic        result_valid_o,
  output logic [31:0] result_nonce_o,
  input  logic        result_ready_i,
  output logic        overflow_o,
  output logic [15:0] found_count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [LATENCY-1:0] dl_vld;
  logic [31:0]        dl_nonce [LATENCY];
  logic [31:0]        mem      [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               ovf_q;
  logic               hit;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  // Valid bits need a known reset; nonce payload is qualified by them and may stay stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_vld <= '0;
    end else if (clear_i) begin
      dl_vld <= '0;
    end else begin
      dl_vld[0] <= nonce_valid_i;
      for (int i = 1; i < LATENCY; i++) begin
        dl_vld[i] <= dl_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dl_nonce[0] <= nonce_i;
    for (int i = 1; i < LATENCY; i++) begin
      dl_nonce[i] <= dl_nonce[i-1];
    end
  end

  assign hit   = dl_vld[LATENCY-1] & success_i;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = ~empty & result_ready_i;
  // A pop on a full FIFO frees the head slot in the same cycle, so the hit still lands.
  assign push  = hit & (~full | pop);
  assign drop  = hit & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) ovf_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear_i) begin
      mem[wr_ptr[AW-1:0]] <= dl_nonce[LATENCY-1];
    end
  end

  assign result_valid_o = ~empty;
  assign result_nonce_o = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  assign overflow_o     = ovf_q;

`ifdef RESULT_COUNT_EN
  logic [15:0] found_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      found_cnt <= '0;
    end else if (clear_i) begin
      found_cnt <= '0;
    end else if (hit && found_cnt != 16'hFFFF) begin
      found_cnt <= found_cnt + 16'd1;
    end
  end

  assign found_count_o = found_cnt;
`else
  assign found_count_o = 16'h0;
`endif

endmodule
